// File: rtl/sysarray_feeder_if.sv
// rtl/sysarray_feeder_if.sv - element load stream and skewed edge outputs of sysarray_feeder
interface sysarray_feeder_if #(
  parameter int N = 5,
  parameter int W = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           out_valid;
  logic [N*W-1:0] a_out;
  logic [N*W-1:0] b_out;
  logic           busy;
  logic           done;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, a_out, b_out, busy, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, a_out, b_out, busy, done
  );
endinterface

// File: rtl/sysarray_feeder.sv
// rtl/sysarray_feeder.sv - buffers A/B matrices and replays them as skewed lane streams
// Macro SYSARRAY_FEEDER_BROW_EN: B loaded row-major instead of column-major.
module sysarray_feeder #(
  parameter int N = 5,
  parameter int W = 32
) (
  input  logic             clock,
  input  logic             resetn,
  sysarray_feeder_if.slave bus
);
  localparam int BW = $clog2(2*N*N);
  localparam int TW = $clog2(2*N-1);
  localparam int NB = $clog2(N);
  localparam logic [BW-1:0] LAST_BEAT = BW'(2*N*N-1);
  localparam logic [BW-1:0] B_FIRST   = BW'(N*N);
  localparam logic [TW-1:0] LAST_T    = TW'(2*N-2);
  localparam logic [NB-1:0] LAST_IDX  = NB'(N-1);

  typedef enum logic [1:0] {ST_LOAD, ST_STREAM, ST_DONE} state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [NB-1:0]  maj_q, maj_d, min_q, min_d;
  logic [TW-1:0]  t_q, t_d;
  logic           wr_en;
  logic [W-1:0]   a_mem [N][N];
  logic [W-1:0]   b_mem [N][N];
  logic [N*W-1:0] a_q, a_d, b_q, b_d;
  logic           valid_q, done_q;

  // maj/min walk the current matrix in load order so no division by N is needed
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    maj_d   = maj_q;
    min_d   = min_q;
    t_d     = t_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (bus.in_valid) begin
          wr_en = 1'b1;
          if (min_q == LAST_IDX) begin
            min_d = '0;
            maj_d = (maj_q == LAST_IDX) ? '0 : maj_q + NB'(1);
          end else begin
            min_d = min_q + NB'(1);
          end
          if (beat_q == LAST_BEAT) begin
            state_d = ST_STREAM;
            beat_d  = '0;
            t_d     = '0;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      ST_STREAM: begin
        if (t_q == LAST_T) begin
          state_d = ST_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      if (beat_q < B_FIRST) begin
        a_mem[maj_q][min_q] <= bus.in_data;
      end else begin
`ifdef SYSARRAY_FEEDER_BROW_EN
        b_mem[maj_q][min_q] <= bus.in_data;
`else
        b_mem[min_q][maj_q] <= bus.in_data;
`endif
      end
    end
  end

  // Outputs are built from the next state so beat t is registered on the edge that counts t.
  always_comb begin
    a_d = '0;
    b_d = '0;
    if (state_d == ST_STREAM) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(t_d) == i + k) begin
            a_d[i*W +: W] = a_mem[i][k];
            b_d[i*W +: W] = b_mem[k][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_LOAD;
      beat_q  <= '0;
      maj_q   <= '0;
      min_q   <= '0;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      maj_q   <= maj_d;
      min_q   <= min_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= (state_d == ST_STREAM);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.busy      = (state_q != ST_LOAD);
  assign bus.out_valid = valid_q;
  assign bus.done      = done_q;
  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
endmodule

// File: tb/tb_sysarray_feeder.sv
// tb/tb_sysarray_feeder.sv - directed bench for sysarray_feeder at N=2 and N=5
module tb_sysarray_feeder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] eb_ref [3];

  always #5 clk = ~clk;

  sysarray_feeder_if #(.N(2), .W(32)) bus2();
  sysarray_feeder_if #(.N(5), .W(32)) bus5();

  sysarray_feeder #(.N(2), .W(32)) u_dut2 (.clock(clk), .resetn(rst_n), .bus(bus2));
  sysarray_feeder #(.N(5), .W(32)) u_dut5 (.clock(clk), .resetn(rst_n), .bus(bus5));

  task automatic load2(input logic [31:0] v [8], input bit gaps);
    int waitc;
    for (int b = 0; b < 8; b++) begin
      waitc = 0;
      bus2.in_valid = 1'b1;
      bus2.in_data  = v[b];
      while (bus2.in_ready !== 1'b1 && waitc < 20) begin
        @(negedge clk);
        waitc++;
      end
      checks++;
      if (waitc >= 20) begin
        errors++;
        $display("FAIL load2_ready beat %0d: in_ready=%b required 1", b, bus2.in_ready);
      end
      @(negedge clk);
      if (gaps && b != 7) begin
        bus2.in_valid = 1'b0;
        bus2.in_data  = 32'hDEAD;
        checks++;
        if (bus2.busy !== 1'b0 || bus2.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL gap_idle after %0d transfers: busy=%b out_valid=%b required 0 0",
                   b + 1, bus2.busy, bus2.out_valid);
        end
        @(negedge clk);
      end
    end
    bus2.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus2.in_valid = 1'b0; bus2.in_data = '0;
    bus5.in_valid = 1'b0; bus5.in_data = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus2.out_valid !== 1'b0 || bus2.a_out !== 64'd0 || bus2.b_out !== 64'd0 ||
        bus2.done !== 1'b0 || bus2.busy !== 1'b0 || bus2.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: v=%b a=%h b=%h done=%b busy=%b rdy=%b required 0 0 0 0 0 1",
               bus2.out_valid, bus2.a_out, bus2.b_out, bus2.done, bus2.busy, bus2.in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_stream();
    logic [31:0] v [8];
    logic [63:0] ea [3];
    v  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    ea = '{{32'd0, 32'd1}, {32'd3, 32'd2}, {32'd4, 32'd0}};
    load2(v, 1'b0);
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (bus2.out_valid !== 1'b1 || bus2.a_out !== ea[t] || bus2.b_out !== eb_ref[t] || bus2.busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_stream t=%0d: v=%b busy=%b a=%h b=%h required 1 1 a=%h b=%h",
                 t, bus2.out_valid, bus2.busy, bus2.a_out, bus2.b_out, ea[t], eb_ref[t]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus2.done !== 1'b1 || bus2.out_valid !== 1'b0 || bus2.a_out !== 64'd0 ||
        bus2.b_out !== 64'd0 || bus2.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: done=%b v=%b a=%h b=%h busy=%b required 1 0 0 0 1",
               bus2.done, bus2.out_valid, bus2.a_out, bus2.b_out, bus2.busy);
    end
    @(negedge clk);
    checks++;
    if (bus2.done !== 1'b0 || bus2.busy !== 1'b0 || bus2.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle: done=%b busy=%b rdy=%b required 0 0 1",
               bus2.done, bus2.busy, bus2.in_ready);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] v [8];
    logic [63:0] ea [3];
    v  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    ea = '{{32'd0, 32'd1}, {32'd3, 32'd2}, {32'd4, 32'd0}};
    load2(v, 1'b1);
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (bus2.out_valid !== 1'b1 || bus2.a_out !== ea[t] || bus2.b_out !== eb_ref[t]) begin
        errors++;
        $display("FAIL gaps_stream t=%0d: v=%b a=%h b=%h required 1 a=%h b=%h",
                 t, bus2.out_valid, bus2.a_out, bus2.b_out, ea[t], eb_ref[t]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus2.done !== 1'b1 || bus2.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL gaps_done: done=%b v=%b required 1 0", bus2.done, bus2.out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_valid_during_stream();
    logic [31:0] v [8];
    logic [31:0] v3 [8];
    logic [63:0] ea [3];
    logic [63:0] ea3 [3];
    v   = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    v3  = '{32'd11, 32'd12, 32'd13, 32'd14, 32'd5, 32'd6, 32'd7, 32'd8};
    ea  = '{{32'd0, 32'd1}, {32'd3, 32'd2}, {32'd4, 32'd0}};
    ea3 = '{{32'd0, 32'd11}, {32'd13, 32'd12}, {32'd14, 32'd0}};
    load2(v, 1'b0);
    bus2.in_valid = 1'b1;
    bus2.in_data  = 32'd99;
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (bus2.in_ready !== 1'b0 || bus2.a_out !== ea[t] || bus2.b_out !== eb_ref[t]) begin
        errors++;
        $display("FAIL hold_stream t=%0d: rdy=%b a=%h b=%h required 0 a=%h b=%h",
                 t, bus2.in_ready, bus2.a_out, bus2.b_out, ea[t], eb_ref[t]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus2.in_ready !== 1'b0 || bus2.done !== 1'b1 || bus2.a_out !== 64'd0) begin
      errors++;
      $display("FAIL hold_done: rdy=%b done=%b a=%h required 0 1 0",
               bus2.in_ready, bus2.done, bus2.a_out);
    end
    load2(v3, 1'b0);
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (bus2.out_valid !== 1'b1 || bus2.a_out !== ea3[t] || bus2.b_out !== eb_ref[t]) begin
        errors++;
        $display("FAIL reload_stream t=%0d: v=%b a=%h b=%h required 1 a=%h b=%h",
                 t, bus2.out_valid, bus2.a_out, bus2.b_out, ea3[t], eb_ref[t]);
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midway();
    logic [31:0] v [8];
    logic [31:0] v4 [8];
    logic [63:0] ea4 [3];
    v   = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    v4  = '{32'd21, 32'd22, 32'd23, 32'd24, 32'd5, 32'd6, 32'd7, 32'd8};
    ea4 = '{{32'd0, 32'd21}, {32'd23, 32'd22}, {32'd24, 32'd0}};
    load2(v, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus2.out_valid !== 1'b0 || bus2.a_out !== 64'd0 || bus2.b_out !== 64'd0 || bus2.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_stream: v=%b a=%h b=%h busy=%b required 0 0 0 0",
               bus2.out_valid, bus2.a_out, bus2.b_out, bus2.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      bus2.in_valid = 1'b1;
      bus2.in_data  = 32'd50 + 32'(b);
      @(negedge clk);
    end
    bus2.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus2.in_ready !== 1'b1 || bus2.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_load: rdy=%b v=%b required 1 0", bus2.in_ready, bus2.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load2(v4, 1'b0);
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (bus2.out_valid !== 1'b1 || bus2.a_out !== ea4[t] || bus2.b_out !== eb_ref[t]) begin
        errors++;
        $display("FAIL fresh_load t=%0d: v=%b a=%h b=%h required 1 a=%h b=%h",
                 t, bus2.out_valid, bus2.a_out, bus2.b_out, ea4[t], eb_ref[t]);
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_n5_identity();
    int waitc;
    int bb;
    logic [159:0] ea;
    logic [159:0] eb;
    for (int b = 0; b < 50; b++) begin
      waitc = 0;
      bus5.in_valid = 1'b1;
      if (b < 25) begin
        bus5.in_data = 32'(10 * (b / 5) + (b % 5));
      end else begin
        bb = b - 25;
        bus5.in_data = ((bb / 5) == (bb % 5)) ? 32'd1 : 32'd0;
      end
      while (bus5.in_ready !== 1'b1 && waitc < 20) begin
        @(negedge clk);
        waitc++;
      end
      checks++;
      if (waitc >= 20) begin
        errors++;
        $display("FAIL n5_ready beat %0d: in_ready=%b required 1", b, bus5.in_ready);
      end
      @(negedge clk);
    end
    bus5.in_valid = 1'b0;
    for (int t = 0; t < 9; t++) begin
      ea = '0;
      eb = '0;
      for (int i = 0; i < 5; i++) begin
        if (t - i >= 0 && t - i < 5) begin
          ea[i*32 +: 32] = 32'(10 * i + (t - i));
          if (t - i == i) eb[i*32 +: 32] = 32'd1;
        end
      end
      checks++;
      if (bus5.out_valid !== 1'b1 || bus5.a_out !== ea || bus5.b_out !== eb) begin
        errors++;
        $display("FAIL n5_stream t=%0d: v=%b a=%h b=%h required 1 a=%h b=%h",
                 t, bus5.out_valid, bus5.a_out, bus5.b_out, ea, eb);
      end
      if (t == 8) begin
        checks++;
        if (bus5.a_out !== {32'd44, 128'd0} || bus5.b_out !== {32'd1, 128'd0}) begin
          errors++;
          $display("FAIL n5_last_beat: a=%h b=%h required lane4 only 44 and 1", bus5.a_out, bus5.b_out);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (bus5.done !== 1'b1 || bus5.out_valid !== 1'b0 || bus5.a_out !== 160'd0) begin
      errors++;
      $display("FAIL n5_done: done=%b v=%b a=%h required 1 0 0", bus5.done, bus5.out_valid, bus5.a_out);
    end
    @(negedge clk);
  endtask

  initial begin
`ifdef SYSARRAY_FEEDER_BROW_EN
    eb_ref = '{{32'd0, 32'd5}, {32'd6, 32'd7}, {32'd8, 32'd0}};
`else
    eb_ref = '{{32'd0, 32'd5}, {32'd7, 32'd6}, {32'd8, 32'd0}};
`endif
    test_reset();
    test_basic_stream();
    test_gaps();
    test_valid_during_stream();
    test_reset_midway();
    test_n5_identity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
